tpg_stream_gen: RTL and testbench

Parametrised successor to the single-pixel test pattern generator: one Avalon-ST Video-style source producing colour bars, scrolling bars, gradient, solid colour and checkerboard frames, with `PIXELS_PER_BEAT` pixels per beat and full ready/valid backpressure. It sits between the register block, which supplies the config ports, and the downstream video pipeline. It replaces the per-pattern output buses plus external mux with a single `mode_i`-selected stream carrying explicit SOP/EOP framing.

---
 rtl/tpg_stream_gen.sv | 186 ++++++++++++++++++
 tb/tb_tpg_stream_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpg_stream_gen.sv
// Test pattern stream source: bars, scrolling bars, gradient, solid and checkerboard frames
// emitted as SOP/EOP-framed packets with ready/valid backpressure.
module tpg_stream_gen #(
   parameter int unsigned BITS_PER_SYMBOL  = 8,
   parameter int unsigned SYMBOLS_PER_BEAT = 3,
   parameter int unsigned PIXELS_PER_BEAT  = 1,
   parameter int unsigned DIM_W            = 16,
   parameter int unsigned CHECK_LOG2       = 4,
   localparam int unsigned PW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          enable_i,
   input  logic [2:0]                    mode_i,
   input  logic                          mode_bw_i,
   input  logic [DIM_W-1:0]              width_i,
   input  logic [DIM_W-1:0]              height_i,
   input  logic [7:0]                    offset_frames_i,
   input  logic [PW-1:0]                 color_i,
   input  logic                          ready_i,
   output logic                          valid_o,
   output logic [PW*PIXELS_PER_BEAT-1:0] data_o,
   output logic                          sop_o,
   output logic                          eop_o,
   output logic [15:0]                   frame_cnt_o,
   output logic                          busy_o
);
   localparam int unsigned B     = BITS_PER_SYMBOL;
   localparam int unsigned G_SYM = (SYMBOLS_PER_BEAT > 1) ? 1 : 0;
   localparam logic [DIM_W:0] PPB_EXT = (DIM_W+1)'(PIXELS_PER_BEAT);
   localparam logic [DIM_W:0] ONE_EXT = (DIM_W+1)'(1);

   typedef enum logic [1:0] {StIdle, StHdr, StActive} state_t;
   state_t state, state_next;

   logic [2:0]       cfg_mode;
   logic             cfg_bw;
   logic [DIM_W-1:0] cfg_width, cfg_height;
   logic [7:0]       cfg_offset;
   logic [PW-1:0]    cfg_color;
   logic [DIM_W-1:0] thr      [1:7];
   logic [DIM_W-1:0] thr_calc [1:7];
   logic [DIM_W+2:0] thr_prod [1:7];
   logic [DIM_W-1:0] x, y;
   logic [2:0]       shift;
   logic [7:0]       scroll_cnt;
   logic [DIM_W:0]   x_end;
   logic             advance, start, x_wrap, last_beat, eop_accept;
   logic [PW*PIXELS_PER_BEAT-1:0] beat_data;

   assign advance    = ready_i | ~valid_o;
   assign start      = enable_i && (width_i != '0) && (height_i != '0);
   assign x_end      = {1'b0, x} + PPB_EXT;
   assign x_wrap     = (x_end == {1'b0, cfg_width});
   assign last_beat  = x_wrap && (({1'b0, y} + ONE_EXT) == {1'b0, cfg_height});
   assign eop_accept = (state == StActive) && valid_o && ready_i && eop_o;

   // Bar edges at width*k/8, built from shifted copies of width.
   always_comb begin
      for (int k = 1; k < 8; k++) begin
         thr_prod[k] = '0;
         if ((k & 1) != 0) thr_prod[k] = thr_prod[k] + {3'b000, width_i};
         if ((k & 2) != 0) thr_prod[k] = thr_prod[k] + {2'b00, width_i, 1'b0};
         if ((k & 4) != 0) thr_prod[k] = thr_prod[k] + {1'b0, width_i, 2'b00};
         thr_calc[k] = DIM_W'(thr_prod[k] >> 3);
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         StIdle:   if (start) state_next = StHdr;
         StHdr:    if (advance) state_next = StActive;
         StActive: if (eop_accept) state_next = StIdle;
         default:  state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= StIdle;
      else       state <= state_next;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o     <= 1'b0;
         sop_o       <= 1'b0;
         eop_o       <= 1'b0;
         data_o      <= '0;
         frame_cnt_o <= '0;
         busy_o      <= 1'b0;
         shift       <= '0;
         scroll_cnt  <= '0;
         x           <= '0;
         y           <= '0;
         cfg_mode    <= '0;
         cfg_bw      <= 1'b0;
         cfg_width   <= '0;
         cfg_height  <= '0;
         cfg_offset  <= '0;
         cfg_color   <= '0;
         for (int k = 1; k < 8; k++) thr[k] <= '0;
      end else begin
         busy_o <= (state_next != StIdle);
         if (state == StIdle) begin
            if (start) begin
               cfg_mode   <= mode_i;
               cfg_bw     <= mode_bw_i;
               cfg_width  <= width_i;
               cfg_height <= height_i;
               cfg_offset <= offset_frames_i;
               cfg_color  <= color_i;
               for (int k = 1; k < 8; k++) thr[k] <= thr_calc[k];
               x       <= '0;
               y       <= '0;
               valid_o <= 1'b1;
               sop_o   <= 1'b1;
               eop_o   <= 1'b0;
               data_o  <= '0;
            end
         end else if (advance) begin
            if (eop_accept) begin
               valid_o     <= 1'b0;
               sop_o       <= 1'b0;
               eop_o       <= 1'b0;
               data_o      <= '0;
               frame_cnt_o <= frame_cnt_o + 16'd1;
               if (cfg_offset != 8'd0 && (scroll_cnt + 8'd1) == cfg_offset) begin
                  shift      <= shift + 3'd1;
                  scroll_cnt <= '0;
               end else begin
                  scroll_cnt <= scroll_cnt + 8'd1;
               end
            end else begin
               valid_o <= 1'b1;
               sop_o   <= 1'b0;
               eop_o   <= last_beat;
               data_o  <= beat_data;
               if (x_wrap) begin
                  x <= '0;
                  y <= y + DIM_W'(1);
               end else begin
                  x <= x_end[DIM_W-1:0];
               end
            end
         end
      end
   end

   for (genvar p = 0; p < PIXELS_PER_BEAT; p++) begin : g_pix
      logic [DIM_W-1:0] xp;
      logic [2:0]       bar_idx, col_idx;
      logic [B-1:0]     chan [3];
      logic [B-1:0]     g_sym;
      logic [PW-1:0]    pix_raw, pix;

      assign xp = x + DIM_W'(p);

      always_comb begin
         bar_idx = '0;
         for (int k = 1; k < 8; k++) begin
            if (xp >= thr[k]) bar_idx = bar_idx + 3'd1;
         end
         col_idx = (cfg_mode == 3'd1) ? bar_idx + shift : bar_idx;
         // Bar index bits map to absent channels: bit0 B, bit1 R, bit2 G.
         chan[0] = col_idx[0] ? '0 : '1;
         chan[1] = col_idx[2] ? '0 : '1;
         chan[2] = col_idx[1] ? '0 : '1;
         if (cfg_mode == 3'd2) begin
            for (int c = 0; c < 3; c++) chan[c] = B'(xp);
         end else if (cfg_mode == 3'd4) begin
            for (int c = 0; c < 3; c++) chan[c] = (xp[CHECK_LOG2] ^ y[CHECK_LOG2]) ? '0 : '1;
         end
         for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
            pix_raw[s*B +: B] = (cfg_mode == 3'd3) ? cfg_color[s*B +: B] : chan[s % 3];
         end
         g_sym = pix_raw[G_SYM*B +: B];
         for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
            pix[s*B +: B] = cfg_bw ? g_sym : pix_raw[s*B +: B];
         end
      end

      assign beat_data[p*PW +: PW] = pix;
   end

endmodule

// File: tb/tb_tpg_stream_gen.sv
// Bench for tpg_stream_gen: directed frames plus randomised frames, checked against a
// pixel-rule reference model on a 1-pixel-per-beat and a 4-pixel-per-beat instance.
module tb_tpg_stream_gen;
   logic        clk = 1'b0;
   logic        rst, en1, en4, bw, ready;
   logic [2:0]  mode;
   logic [15:0] width, height;
   logic [7:0]  offset;
   logic [23:0] color;

   logic        v1, s1, e1, b1, v4, s4, e4, b4;
   logic [23:0] d1;
   logic [95:0] d4;
   logic [15:0] fc1, fc4;

   int          sel;
   logic        v, s, e, b;
   logic [95:0] d;
   logic [15:0] fc;

   int n_tests, n_fail;
   int fc_m [2];
   int scnt_m [2];
   int shift_m [2];
   int t_mode, t_bw, t_w, t_h, t_off;
   logic [23:0] t_color;
   logic [95:0] cap_q [$];

   always #5 clk = ~clk;

   tpg_stream_gen #(.PIXELS_PER_BEAT(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .enable_i(en1), .mode_i(mode), .mode_bw_i(bw),
      .width_i(width), .height_i(height), .offset_frames_i(offset), .color_i(color),
      .ready_i(ready), .valid_o(v1), .data_o(d1), .sop_o(s1), .eop_o(e1),
      .frame_cnt_o(fc1), .busy_o(b1)
   );

   tpg_stream_gen #(.PIXELS_PER_BEAT(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .enable_i(en4), .mode_i(mode), .mode_bw_i(bw),
      .width_i(width), .height_i(height), .offset_frames_i(offset), .color_i(color),
      .ready_i(ready), .valid_o(v4), .data_o(d4), .sop_o(s4), .eop_o(e4),
      .frame_cnt_o(fc4), .busy_o(b4)
   );

   always_comb begin
      if (sel == 4) begin
         v = v4; d = d4; s = s4; e = e4; b = b4; fc = fc4;
      end else begin
         v = v1; d = {72'b0, d1}; s = s1; e = e1; b = b1; fc = fc1;
      end
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] bar_rgb(input int i);
      case (i)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] model_pix(input int xx, input int yy, input int sh);
      int bi;
      logic [23:0] px;
      logic [7:0] g;
      bi = 0;
      for (int k = 1; k < 8; k++) if (xx >= (t_w * k) / 8) bi++;
      case (t_mode)
         1: px = bar_rgb((bi + sh) % 8);
         2: begin g = 8'(xx); px = {g, g, g}; end
         3: px = t_color;
         4: px = ((((xx >> 4) ^ (yy >> 4)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
         default: px = bar_rgb(bi);
      endcase
      if (t_bw != 0) begin
         g = px[15:8];
         px = {g, g, g};
      end
      return px;
   endfunction

   function automatic logic [95:0] exp_beat(input int idx, input int ppb, input int sh);
      logic [95:0] r;
      int j;
      r = '0;
      if (idx == 0) return r;
      j = (idx - 1) * ppb;
      for (int p = 0; p < ppb; p++) r[p*24 +: 24] = model_pix((j + p) % t_w, (j + p) / t_w, sh);
      return r;
   endfunction

   function automatic logic [95:0] cap_at(input int i);
      if (i < cap_q.size()) return cap_q[i];
      return '1;
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 2; i++) begin
         fc_m[i] = 0; scnt_m[i] = 0; shift_m[i] = 0;
      end
   endtask

   task automatic set_cfg(input int m, input int w_bw, input int w, input int h, input int off,
                          input logic [23:0] c);
      t_mode = m; t_bw = w_bw; t_w = w; t_h = h; t_off = off; t_color = c;
   endtask

   task automatic drive_cfg();
      mode = 3'(t_mode); bw = (t_bw != 0); width = 16'(t_w); height = 16'(t_h);
      offset = 8'(t_off); color = t_color;
   endtask

   task automatic scramble_cfg();
      mode = 3'($urandom_range(7)); bw = 1'($urandom_range(1)); width = 16'($urandom);
      height = 16'($urandom); offset = 8'($urandom); color = 24'($urandom);
   endtask

   // Runs one frame on the selected unit, checking every accepted beat against the model.
   task automatic run_frame(input int which, input int pct, input bit last, input bit scramble,
                            input int exp_gap, output int nbeats);
      int ppb, si, total, limit, idx, gap, nbad, nstall, cyc, sh;
      bit done, seen, stalled;
      logic [95:0] pd, ed;
      logic ps, pe;
      ppb = (which == 4) ? 4 : 1;
      si = (which == 4) ? 1 : 0;
      total = t_w * t_h / ppb;
      limit = (total + 1) * 20 + 50;
      idx = 0; gap = 0; nbad = 0; nstall = 0; cyc = 0; sh = shift_m[si];
      done = 0; seen = 0; stalled = 0; pd = '0; ps = 0; pe = 0;
      cap_q.delete();
      sel = which;
      drive_cfg();
      if (which == 4) en4 = 1'b1; else en1 = 1'b1;
      while (!done && cyc < limit) begin
         @(negedge clk);
         cyc++;
         ready = ($urandom_range(99) < pct);
         if (!v) begin
            if (stalled) nstall++;
            if (seen) nbad++; else gap++;
            stalled = 0;
         end else begin
            if (stalled && (d !== pd || s !== ps || e !== pe)) nstall++;
            seen = 1;
            if (b !== 1'b1) nbad++;
            if (ready) begin
               ed = exp_beat(idx, ppb, sh);
               if (d !== ed || s !== (idx == 0) || e !== (idx == total)) begin
                  if (nbad == 0)
                     $display("[TB] unit %0d beat %0d: data %0h sop %0b eop %0b, model %0h sop %0b eop %0b",
                              which, idx, d, s, e, ed, idx == 0, idx == total);
                  nbad++;
               end
               cap_q.push_back(d);
               idx++;
               if (scramble && idx == 1) scramble_cfg();
               if (e || idx > total) begin
                  done = 1;
                  if (last) begin
                     if (which == 4) en4 = 1'b0; else en1 = 1'b0;
                  end
                  drive_cfg();
               end
               stalled = 0;
            end else begin
               stalled = 1; pd = d; ps = s; pe = e;
            end
         end
      end
      if (!done) begin
         en1 = 1'b0; en4 = 1'b0; drive_cfg();
      end
      @(posedge clk);
      #1;
      if (done) begin
         fc_m[si] = (fc_m[si] + 1) % 65536;
         scnt_m[si] = (scnt_m[si] + 1) % 256;
         if (t_off != 0 && scnt_m[si] == t_off) begin
            shift_m[si] = (shift_m[si] + 1) % 8;
            scnt_m[si] = 0;
         end
      end
      nbeats = idx;
      check_eq("frame completes", done, 1);
      check_eq("beat count", idx, total + 1);
      check_eq("frame beats vs model", nbad, 0);
      check_eq("stall hold", nstall, 0);
      check_eq("frame_cnt", fc, fc_m[si]);
      check_eq("busy after eop", b, 0);
      if (exp_gap >= 0) check_eq("frame gap", gap, exp_gap);
   endtask

   initial begin
      int nb, cnt;
      logic [95:0] tmp;
      logic [23:0] first_pix [4];
      rst = 1'b1; en1 = 1'b0; en4 = 1'b0; ready = 1'b0; sel = 1;
      n_tests = 0; n_fail = 0;
      reset_model();
      set_cfg(0, 0, 16, 1, 0, 24'h0);
      drive_cfg();
      #1;
      check_eq("reset valid", v1, 0);
      check_eq("reset sop/eop", {s1, e1}, 0);
      check_eq("reset data", d1, 0);
      check_eq("reset frame_cnt", fc1, 0);
      check_eq("reset busy", b1, 0);
      check_eq("reset valid x4", v4, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Scroll every two frames: frames 1-2 lead with white, 3-4 with yellow.
      set_cfg(1, 0, 16, 1, 2, 24'h0);
      for (int f = 0; f < 4; f++) begin
         run_frame(1, 100, f == 3, 0, (f == 0) ? -1 : 1, nb);
         tmp = cap_at(1);
         first_pix[f] = tmp[23:0];
      end
      check_eq("scroll f1", first_pix[0], 24'hFFFFFF);
      check_eq("scroll f2", first_pix[1], 24'hFFFFFF);
      check_eq("scroll f3", first_pix[2], 24'hFFFF00);
      check_eq("scroll f4", first_pix[3], 24'hFFFF00);

      set_cfg(0, 0, 16, 2, 0, 24'h0);
      run_frame(1, 100, 1, 0, -1, nb);
      check_eq("bars beats", nb, 33);
      check_eq("bars header", cap_at(0), 0);
      check_eq("bars x2 yellow", cap_at(3), 24'hFFFF00);
      check_eq("bars x14 black", cap_at(15), 24'h000000);

      set_cfg(0, 1, 16, 1, 0, 24'h0);
      run_frame(1, 100, 1, 0, -1, nb);
      check_eq("bw yellow", cap_at(3), 24'hFFFFFF);
      check_eq("bw magenta", cap_at(9), 24'h000000);

      set_cfg(2, 0, 8, 1, 0, 24'h0);
      run_frame(4, 100, 1, 0, -1, nb);
      check_eq("grad4 beats", nb, 3);
      check_eq("grad4 beat1", cap_at(1), 96'h030303_020202_010101_000000);
      check_eq("grad4 beat2", cap_at(2), 96'h070707_060606_050505_040404);

      set_cfg(3, 0, 600, 4, 0, 24'h123456);
      run_frame(1, 50, 1, 1, -1, nb);
      check_eq("solid beats", nb, 2401);
      check_eq("solid last pixel", cap_at(2400), 24'h123456);

      sel = 1;
      en1 = 1'b1; mode = 3'd0; width = 16'd0; height = 16'd5;
      cnt = 0;
      repeat (6) begin @(negedge clk); if (v1 || b1) cnt++; end
      width = 16'd5; height = 16'd0;
      repeat (6) begin @(negedge clk); if (v1 || b1) cnt++; end
      en1 = 1'b0;
      check_eq("zero-size gate", cnt, 0);

      set_cfg(0, 0, 16, 4, 0, 24'h0);
      drive_cfg();
      en1 = 1'b1; ready = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("pre-reset valid", v1, 1);
      rst = 1'b1; en1 = 1'b0;
      @(posedge clk);
      #1;
      check_eq("mid reset valid", v1, 0);
      check_eq("mid reset frame_cnt", fc1, 0);
      check_eq("mid reset sop/eop/busy", {s1, e1, b1}, 0);
      check_eq("mid reset data", d1, 0);
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      run_frame(1, 100, 1, 0, -1, nb);

      for (int n = 0; n < 12; n++) begin
         int which, ppb, nf, pct, scr;
         which = ($urandom_range(1) == 1) ? 4 : 1;
         ppb = (which == 4) ? 4 : 1;
         set_cfg($urandom_range(7), ($urandom_range(3) == 0) ? 1 : 0,
                 ppb * $urandom_range(1, 40 / ppb), $urandom_range(1, 20), $urandom_range(0, 3),
                 24'($urandom));
         nf = $urandom_range(1, 3);
         pct = $urandom_range(30, 100);
         scr = $urandom_range(1);
         for (int f = 0; f < nf; f++) run_frame(which, pct, f == nf - 1, scr != 0,
                                                (f == 0) ? -1 : 1, nb);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
